// File: rtl/wfifo_burst_arbiter.sv
// Two-channel write-FIFO drain arbiter: grants fixed-length bursts to whichever
// channel holds a full burst, issues the burst command, then streams the words.
module wfifo_burst_arbiter #(
  parameter int DW           = 32,
  parameter int BURST_LEN    = 16,
  parameter int LVL_W        = 11,
  parameter int ADDR_W       = 28,
  parameter int CH0_BASE     = 0,
  parameter int CH1_BASE     = 1 << 20,
  parameter int REGION_WORDS = 1 << 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DW-1:0]     ch0_data,
  input  logic              ch0_vld,
  output logic              ch0_en,
  input  logic [LVL_W-1:0]  ch0_level,
  input  logic [DW-1:0]     ch1_data,
  input  logic              ch1_vld,
  output logic              ch1_en,
  input  logic [LVL_W-1:0]  ch1_level,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              cmd_ch,
  output logic [DW-1:0]     wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [LVL_W-1:0]  LVL_BURST  = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_BURST = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_WRAP  = ADDR_W'(REGION_WORDS);
  localparam logic [ADDR_W-1:0] BASE0      = ADDR_W'(CH0_BASE);
  localparam logic [ADDR_W-1:0] BASE1      = ADDR_W'(CH1_BASE);
  localparam logic [CW-1:0]     LAST_BEAT  = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] ptr0;
  logic [ADDR_W-1:0] ptr1;
  logic              last_grant;
  logic              elig0;
  logic              elig1;
  logic              grant;
  logic              in_data;
  logic              accept;
  logic              last_beat;
  logic [ADDR_W-1:0] ptr_sum;
  logic [ADDR_W-1:0] ptr_next;

  // Levels only matter in IDLE; they are ignored in CMD/DATA by construction.
  assign elig0 = (ch0_level >= LVL_BURST);
  assign elig1 = (ch1_level >= LVL_BURST);
  // On a tie the channel not served last wins; otherwise the eligible one.
  assign grant = (elig0 && elig1) ? ~last_grant : elig1;

  // Handshakes: cmd transfers on cmd_valid & cmd_ready, a data beat transfers on
  // wvalid & wready; the producer holds its payload stable until the transfer.
  assign in_data   = (state == DATA);
  assign wdata     = cmd_ch ? ch1_data : ch0_data;
  assign wvalid    = in_data && (cmd_ch ? ch1_vld : ch0_vld);
  assign ch0_en    = in_data && !cmd_ch && wready;
  assign ch1_en    = in_data &&  cmd_ch && wready;
  assign accept    = wvalid && wready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign wlast     = in_data && last_beat;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign cmd_len   = 8'(BURST_LEN - 1);

  assign ptr_sum  = (cmd_ch ? ptr1 : ptr0) + ADDR_BURST;
  assign ptr_next = (ptr_sum == ADDR_WRAP) ? '0 : ptr_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_ch     <= 1'b0;
      beat_cnt   <= '0;
      ptr0       <= '0;
      ptr1       <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (elig0 || elig1)) begin
            state      <= CMD;
            cmd_valid  <= 1'b1;
            cmd_ch     <= grant;
            last_grant <= grant;
            cmd_addr   <= grant ? (BASE1 + ptr1) : (BASE0 + ptr0);
          end
        end
        CMD: begin
          if (cmd_ready) begin
            state     <= DATA;
            cmd_valid <= 1'b0;
            beat_cnt  <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            if (last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
              if (cmd_ch) ptr1 <= ptr_next;
              else        ptr0 <= ptr_next;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfifo_burst_arbiter.sv
// Directed bench for wfifo_burst_arbiter: a table of burst scenarios applied in
// sequence, with FIFO data modelled as per-channel word counters.
module tb_wfifo_burst_arbiter;

  localparam logic [31:0] D0 = 32'hC000_0000;
  localparam logic [31:0] D1 = 32'hD100_0000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] ch0_data, ch1_data;
  logic        ch0_vld, ch1_vld;
  logic        ch0_en, ch1_en;
  logic [10:0] ch0_level, ch1_level;
  logic        cmd_valid, cmd_ready;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_ch;
  logic [31:0] wdata;
  logic        wvalid, wready, wlast;
  logic        busy;
  logic [1:0]  state_dbg;

  wfifo_burst_arbiter #(.REGION_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch0_data(ch0_data), .ch0_vld(ch0_vld), .ch0_en(ch0_en), .ch0_level(ch0_level),
    .ch1_data(ch1_data), .ch1_vld(ch1_vld), .ch1_en(ch1_en), .ch1_level(ch1_level),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ch(cmd_ch),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          lvl0;
    int          lvl1;
    int          ready_dly;
    bit          wr_toggle;
    int          gap_beat;
    int          en_drop;
    int          rst_beat;
    bit          clr_lvl;
    bit          exp_ch;
    logic [27:0] exp_addr;
  } vec_t;

  vec_t        vecs[11];
  int          errors = 0;
  int          checks = 0;
  int          pop0 = 0;
  int          pop1 = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: runs one burst from IDLE; entered and left at a falling edge
  task automatic run_burst(input vec_t v);
    int   waitc, beats, cyc, gap_left, p0s, p1s;
    bit   pend0, pend1, aborted, vld_now;
    ch0_level = 11'(v.lvl0);
    ch1_level = 11'(v.lvl1);
    enable    = 1'b1;
    cmd_ready = 1'b0;
    wready    = 1'b0;
    waitc = 0;
    do begin
      @(negedge clk); #1;
      waitc++;
    end while (!cmd_valid && waitc < 8);
    chk("cmd_latency", 32'(waitc), 32'd1);
    chk("cmd_valid", {31'b0, cmd_valid}, 32'd1);
    chk("cmd_ch", {31'b0, cmd_ch}, {31'b0, v.exp_ch});
    chk("cmd_addr", {4'b0, cmd_addr}, {4'b0, v.exp_addr});
    chk("cmd_len", {24'b0, cmd_len}, 32'd15);
    chk("busy_cmd", {31'b0, busy}, 32'd1);
    if (v.clr_lvl) begin
      ch0_level = '0;
      ch1_level = '0;
    end
    p0s = pop0;
    p1s = pop1;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      exp_q.push_back(v.exp_ch ? (D1 | 32'(pop1 + i)) : (D0 | 32'(pop0 + i)));
    for (int i = 0; i < v.ready_dly; i++) begin
      @(negedge clk); #1;
      chk("cmd_hold_valid", {31'b0, cmd_valid}, 32'd1);
      chk("cmd_hold_addr", {4'b0, cmd_addr}, {4'b0, v.exp_addr});
      chk("cmd_hold_ch", {31'b0, cmd_ch}, {31'b0, v.exp_ch});
      chk("cmd_no_pop", {30'b0, ch1_en, ch0_en}, 32'd0);
    end
    cmd_ready = 1'b1;
    beats = 0; cyc = 0; gap_left = 2; pend0 = 0; pend1 = 0; aborted = 0;
    while (beats < 16 && cyc < 200) begin
      @(negedge clk);
      cmd_ready = 1'b0;
      if (pend0) begin pop0++; ch0_data = D0 | 32'(pop0); end
      if (pend1) begin pop1++; ch1_data = D1 | 32'(pop1); end
      if (v.rst_beat == beats) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ch0_en", {31'b0, ch0_en}, 32'd0);
        chk("rst_ch1_en", {31'b0, ch1_en}, 32'd0);
        chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wlast", {31'b0, wlast}, 32'd0);
        chk("rst_cmd_ch", {31'b0, cmd_ch}, 32'd0);
        aborted = 1;
        break;
      end
      cyc++;
      wready = v.wr_toggle ? (cyc % 2 == 1) : 1'b1;
      if (beats == v.gap_beat && gap_left > 0) begin
        vld_now = 1'b0;
        gap_left--;
      end else begin
        vld_now = 1'b1;
      end
      ch0_vld = vld_now;
      ch1_vld = vld_now;
      #1;
      chk("busy_data", {31'b0, busy}, 32'd1);
      chk("cmd_valid_data", {31'b0, cmd_valid}, 32'd0);
      chk("wvalid", {31'b0, wvalid}, {31'b0, vld_now});
      chk("en_granted", {31'b0, v.exp_ch ? ch1_en : ch0_en}, {31'b0, wready});
      chk("en_other", {31'b0, v.exp_ch ? ch0_en : ch1_en}, 32'd0);
      chk("wlast", {31'b0, wlast}, {31'b0, beats == 15});
      if (wvalid && wready) begin
        chk("wdata", wdata, exp_q.pop_front());
        beats++;
        if (beats == v.en_drop) enable = 1'b0;
      end
      pend0 = ch0_en && ch0_vld;
      pend1 = ch1_en && ch1_vld;
    end
    if (aborted) begin
      chk("abort_pops", 32'((v.exp_ch ? pop1 - p1s : pop0 - p0s)), 32'(v.rst_beat));
      @(negedge clk); #1;
      chk("rst_hold_en", {30'b0, ch1_en, ch0_en}, 32'd0);
      rst_n = 1'b1;
      return;
    end
    chk("beats", 32'(beats), 32'd16);
    @(negedge clk);
    if (pend0) begin pop0++; ch0_data = D0 | 32'(pop0); end
    if (pend1) begin pop1++; ch1_data = D1 | 32'(pop1); end
    #1;
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("state_after", {30'b0, state_dbg}, 32'd0);
    chk("en_after", {30'b0, ch1_en, ch0_en}, 32'd0);
    chk("wlast_after", {31'b0, wlast}, 32'd0);
    chk("pops_granted", 32'(v.exp_ch ? pop1 - p1s : pop0 - p0s), 32'd16);
    chk("pops_other", 32'(v.exp_ch ? pop0 - p0s : pop1 - p1s), 32'd0);
    if (v.clr_lvl || !enable) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); #1;
        chk("stay_idle", {31'b0, busy}, 32'd0);
      end
    end
  endtask

  initial begin
    // lvl0 lvl1 rdy tog gap endrop rst clr ch addr   (region is 32 words)
    vecs[0]  = '{16, 0,  0, 0, -1, -1, -1, 1, 0, 28'h0000000};
    vecs[1]  = '{32, 32, 0, 0, -1, -1, -1, 1, 1, 28'h0100000};
    vecs[2]  = '{32, 32, 0, 0, -1, -1, -1, 1, 0, 28'h0000010};
    vecs[3]  = '{32, 32, 0, 0, -1, -1, -1, 1, 1, 28'h0100010};
    vecs[4]  = '{20, 15, 5, 1, -1, -1, -1, 1, 0, 28'h0000000};
    vecs[5]  = '{10, 16, 0, 0,  3, -1, -1, 1, 1, 28'h0100000};
    vecs[6]  = '{16, 16, 0, 0, -1, -1, -1, 1, 0, 28'h0000010};
    vecs[7]  = '{15, 16, 0, 0, -1, -1, -1, 1, 1, 28'h0100010};
    vecs[8]  = '{32, 32, 0, 0, -1,  5, -1, 0, 0, 28'h0000000};
    vecs[9]  = '{32, 32, 0, 0, -1, -1,  8, 1, 1, 28'h0100000};
    vecs[10] = '{32, 32, 0, 0, -1, -1, -1, 1, 0, 28'h0000000};

    rst_n = 1'b0; enable = 1'b0; cmd_ready = 1'b0; wready = 1'b0;
    ch0_vld = 1'b1; ch1_vld = 1'b1;
    ch0_level = '0; ch1_level = '0;
    ch0_data = D0; ch1_data = D1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_state", {30'b0, state_dbg}, 32'd0);
    chk("reset_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("reset_wlast", {31'b0, wlast}, 32'd0);
    chk("reset_en", {30'b0, ch1_en, ch0_en}, 32'd0);
    chk("reset_cmd_ch", {31'b0, cmd_ch}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // enable low with eligible levels must not grant
    ch0_level = 11'd40;
    repeat (2) @(negedge clk);
    #1;
    chk("no_grant_disabled", {31'b0, busy}, 32'd0);
    ch0_level = '0;

    for (int k = 0; k < 11; k++) run_burst(vecs[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
